// File: rtl/demux_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : demux_frame_rx
// Purpose  : Serial frame receiver and channel demultiplexer. It decodes
//            frames of the form start(1) | addr(ADDR_W, MSB first) |
//            data(DATA_W, MSB first) | even parity(1). A frame with good
//            parity is written into the hold register of channel addr. A frame
//            with bad parity is dropped and counted.
// Ports    : Clock   - sole clock, rising edge
//            Resetn  - asynchronous active-low reset
//            din     - serial input line
//            din_en  - qualifies din; the FSM advances only when this is 1
//            abort   - synchronous discard of any partial frame
//            ch_out  - NCH channel hold registers, channel k at [k*DATA_W +: DATA_W]
//            upd     - one-hot, one-cycle strobe for the channel just written
//            perr    - one-cycle parity-error pulse
//            err_cnt - saturating parity-error count
//            busy    - FSM is not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module demux_frame_rx #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  localparam int NCH   = 2**ADDR_W
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                din,
  input  logic                din_en,
  input  logic                abort,
  output logic [NCH*DATA_W-1:0] ch_out,
  output logic [NCH-1:0]      upd,
  output logic                perr,
  output logic [3:0]          err_cnt,
  output logic                busy
);

  localparam int SH_W  = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [SH_W-1:0]         sh_q,    sh_d;
  logic [NCH*DATA_W-1:0]   ch_q,    ch_d;
  logic [NCH-1:0]          upd_q,   upd_d;
  logic                    perr_q,  perr_d;
  logic [3:0]              err_q,   err_d;

  // Once DATA is complete, the shift register holds {addr, data}.
  logic [ADDR_W-1:0]       frame_addr;
  logic [DATA_W-1:0]       frame_data;
  assign frame_addr = sh_q[SH_W-1:DATA_W];
  assign frame_data = sh_q[DATA_W-1:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ch_q    <= '0;
      upd_q   <= '0;
      perr_q  <= 1'b0;
      err_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ch_q    <= ch_d;
      upd_q   <= upd_d;
      perr_q  <= perr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ch_d    = ch_q;
    upd_d   = '0;     // strobes last exactly one cycle
    perr_d  = 1'b0;
    err_d   = err_q;

    // abort has priority over everything, including a parity sample.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (din_en) begin
      case (state_q)
        IDLE: begin
          if (din) begin
            state_d = ADDR;
            cnt_d   = '0;
          end
        end
        ADDR: begin
          sh_d = {sh_q[SH_W-2:0], din};
          if (cnt_q == ADDR_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          sh_d = {sh_q[SH_W-2:0], din};
          if (cnt_q == DATA_LAST) begin
            state_d = PAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAR: begin
          // Returning straight to IDLE lets the next start bit arrive while
          // upd/perr is still high.
          state_d = IDLE;
          cnt_d   = '0;
          if (^{sh_q, din} == 1'b0) begin
            ch_d[int'(frame_addr)*DATA_W +: DATA_W] = frame_data;
            upd_d[frame_addr]                       = 1'b1;
          end else begin
            perr_d = 1'b1;
            if (err_q != 4'hF) begin
              err_d = err_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign ch_out  = ch_q;
  assign upd     = upd_q;
  assign perr    = perr_q;
  assign err_cnt = err_q;
  assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_demux_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_frame_rx
// Purpose  : Self-checking bench for demux_frame_rx. Expected frame outcomes
//            are queued when the parity bit is driven. They are popped and
//            compared when the DUT strobes upd or perr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_frame_rx;

  logic        Clock;
  logic        Resetn;
  logic        din;
  logic        din_en;
  logic        abort;
  logic [15:0] ch_out;
  logic [3:0]  upd;
  logic        perr;
  logic [3:0]  err_cnt;
  logic        busy;

  demux_frame_rx #(.DATA_W(4), .ADDR_W(2)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .din     (din),
    .din_en  (din_en),
    .abort   (abort),
    .ch_out  (ch_out),
    .upd     (upd),
    .perr    (perr),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       is_err;
    logic [1:0] addr;
    logic [3:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_ch;
  logic [3:0]  m_err;
  int          n_cmp;
  int          n_bad;
  int          perr_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge Clock) begin
    if (Resetn && (upd != 4'd0 || perr)) begin
      if (perr) perr_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_event", {upd, 3'b0, perr}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.is_err) begin
          m_err = (m_err == 4'hF) ? 4'hF : m_err + 4'd1;
          check("perr", perr, 1);
          check("upd_on_err", upd, 0);
        end else begin
          m_ch[e.addr*4 +: 4] = e.data;
          check("upd", upd, 64'(4'b0001 << e.addr));
          check("perr_on_good", perr, 0);
        end
        check("ch_out", ch_out, m_ch);
        check("err_cnt", err_cnt, m_err);
      end
    end
  end

  task automatic send_bit(input logic b, input int gap);
    din    = b;
    din_en = 1'b1;
    @(posedge Clock); #1;
    din_en = 1'b0;
    din    = 1'b0;
    repeat (gap) begin
      @(posedge Clock); #1;
    end
  endtask

  task automatic send_frame(input logic [1:0] a, input logic [3:0] d,
                            input bit bad, input int gap, input bit chk_busy);
    logic [7:0] f;
    exp_t       e;
    f = {1'b1, a, d, (^{a, d}) ^ bad};
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin
        e.is_err = bad;
        e.addr   = a;
        e.data   = d;
        sb_q.push_back(e);
      end
      send_bit(f[i], gap);
      if (chk_busy && i > 0) check("busy_in_frame", busy, 1);
    end
    if (chk_busy) check("busy_after_par", busy, 0);
  endtask

  initial begin
    int p0;
    n_cmp = 0; n_bad = 0; perr_seen = 0;
    m_ch = '0; m_err = '0;
    din = 0; din_en = 0; abort = 0;
    Resetn = 0;
    #12;
    check("rst_ch_out", ch_out, 0);
    check("rst_upd", upd, 0);
    check("rst_perr", perr, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_busy", busy, 0);
    Resetn = 1;
    @(posedge Clock); #1;

    // Qualified zeros in IDLE are ignored.
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    check("idle_zero", busy, 0);

    // addr 2, data B, good parity
    send_frame(2'd2, 4'hB, 1'b0, 0, 1'b1);
    @(posedge Clock); #1;
    // same frame with flipped parity
    send_frame(2'd2, 4'hB, 1'b1, 0, 1'b1);
    @(posedge Clock); #1;
    // gapped frame to channel 3 so the write is observable
    send_frame(2'd3, 4'hB, 1'b0, 3, 1'b1);
    @(posedge Clock); #1;

    // abort after the 2nd data bit
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    send_bit(1'b1, 0); send_bit(1'b0, 0);
    abort = 1; @(posedge Clock); #1; abort = 0;
    check("abort_busy", busy, 0);
    send_frame(2'd1, 4'h6, 1'b0, 0, 1'b1);
    @(posedge Clock); #1;

    // abort coincident with the parity sample wins
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b0, 0);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    din = 1'b1; din_en = 1'b1; abort = 1'b1;
    @(posedge Clock); #1;
    din = 1'b0; din_en = 1'b0; abort = 1'b0;
    check("abort_par_busy", busy, 0);
    @(posedge Clock); #1;

    // asynchronous reset mid-DATA
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b0, 0);
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    check("pre_rst_busy", busy, 1);
    #2 Resetn = 0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_ch", ch_out, 0);
    check("async_rst_err", err_cnt, 0);
    m_ch = '0; m_err = '0;
    #3 Resetn = 1;
    @(posedge Clock); #1;
    send_frame(2'd0, 4'h9, 1'b0, 0, 1'b1);
    @(posedge Clock); #1;

    // 17 back-to-back bad frames
    p0 = perr_seen;
    for (int k = 0; k < 17; k++) begin
      send_frame(2'(k), 4'(k), 1'b1, 0, 1'b0);
    end
    repeat (3) @(posedge Clock);
    #1;
    check("perr_pulses", perr_seen - p0, 17);
    check("err_sat", err_cnt, 15);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
